fuzzy_sweep_gen: RTL and testbench
==================================

Name: fuzzy_sweep_gen

Overview:
Synthesizable stimulus/response sequencer for the fuzzy controller, parametrised in channel count, width, step and settle time. It sweeps every input channel over a clamped grid in odometer order and drives the vector into the controller. After a programmable settle interval it captures the defuzzified output and streams it out on a valid/ready interface with a vector index. It sits beside Fuzzy_1 on the FPGA for on-chip surface characterisation, in single-shot or continuous mode.

Parameters:
W, 8, bits per input channel
N_CH, 2, number of input channels
STEP, 16, raw increment per grid point (>=1)
RAW_MAX, 256, last raw grid value (inclusive); must be < 2^(W+1)
CLAMP_LO, 1, minimum value driven on any channel
CLAMP_HI, 254, maximum value driven on any channel
SETTLE_CYC, 28, cycles each vector is applied before capture (>=1)
OUT_W, 8, controller output width
IDX_W, 16, result index width

Ports:
clk_0  in  1  system clock, rising edge
Srst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse, starts a sweep when not busy
abort  in  1  one-cycle pulse, cancels the sweep
continuous  in  1  1 = restart the sweep at wrap, 0 = single sweep; sampled at start
stim_en  out  1  enable to controller (EN_REGRAS); high while busy
stim_out  out  N_CH*W  channel k on bits [k*W +: W]
dut_out  in  OUT_W  controller defuzzified output
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  OUT_W  captured dut_out
res_index  out  IDX_W  vector number within the current sweep
sweep_count  out  8  completed sweeps in continuous mode, wraps mod 256
busy  out  1  state not IDLE/DONE
done  out  1  single sweep finished; held until next start or reset

Behaviour:
- Reset (async, Srst=1): state IDLE; raw counters 0; all outputs 0, including stim_out (forced 0, not clamped) and done.
- Per channel raw counter of W+1 bits. Values 0, STEP, 2*STEP, ... while <= RAW_MAX. NPTS = RAW_MAX/STEP+1 (17 by default). Total vectors = NPTS^N_CH (289 by default).
- Drive value = clamp(raw, CLAMP_LO, CLAMP_HI). Output combinationally from registered counters, so stim_out changes the cycle after the counter edge.
- Odometer order: channel N_CH-1 varies fastest, channel 0 slowest. Carry occurs when a channel is at its last point.
- States: IDLE, SETTLE, CAPTURE, DONE.
- IDLE/DONE + start (and abort=0): counters := 0, res_index := 0, latch continuous, settle counter := SETTLE_CYC-1, go SETTLE, done := 0.
- SETTLE: settle counter decrements each cycle. At the edge where it is 0, res_data := dut_out and res_valid := 1, go CAPTURE. res_valid rises exactly SETTLE_CYC edges after the edge that applied the vector.
- CAPTURE: while res_ready=0, hold res_valid, res_data, res_index, stim_out. On a cycle with res_valid & res_ready:
  - clear res_valid.
  - Not last vector: advance odometer, res_index+1, reload settle counter, go SETTLE.
  - Last vector, continuous=1: counters := 0, res_index := 0, sweep_count+1, go SETTLE.
  - Last vector, continuous=0: go DONE, done := 1.
- abort in any state: next edge to IDLE, res_valid := 0, busy := 0. Counters and stim_out freeze at their current value. done is unchanged.
- abort and start in the same cycle: abort wins.
- start while busy: ignored.
- res_index wraps mod 2^IDX_W.
- stim_en = busy.

Test Plan:
- Srst=1 mid-sweep (index 50) -> same cycle: res_valid, busy, stim_out, res_index, sweep_count all 0; state IDLE.
- Defaults, res_ready=1, dut_out = ch0 XOR ch1:
  - index 0 carries stim {ch0=1, ch1=1}.
  - index 1 carries {1,16}; index 17 carries {16,1}.
  - index 288 carries {254,254}, res_data 0.
  - then done=1, busy=0, exactly 289 results.
- SETTLE_CYC=4, start pulsed at edge E0 -> res_valid first high after edge E4. stim_out constant from E0+ through capture.
- Hold res_ready=0 for 10 cycles at index 5 -> res_valid, res_data, res_index=5 and stim_out stable; index 6 appears only after ready.
- continuous=1, 2 sweeps -> res_index wraps 288->0, sweep_count 0->1->2, done stays 0.
- abort at index 100 -> next cycle IDLE, res_valid=0, stim_en=0. New start -> res_index 0, stim {1,1}.

Source files
------------

// File: rtl/fuzzy_sweep_gen_if.sv
// Result stream between the sweep sequencer and its consumer.
// valid/ready: a result transfers on any rising edge where res_valid and res_ready are both high;
// once raised, res_valid, res_data and res_index stay stable until that transfer (or an abort).
interface fuzzy_sweep_gen_if #(
  parameter int OUT_W = 8,
  parameter int IDX_W = 16
);
  logic             res_valid;
  logic             res_ready;
  logic [OUT_W-1:0] res_data;
  logic [IDX_W-1:0] res_index;

  modport master (output res_valid, output res_data, output res_index, input res_ready);
  modport slave  (input res_valid, input res_data, input res_index, output res_ready);
endinterface

// File: rtl/fuzzy_sweep_gen.sv
// Sweeps all controller inputs over a clamped grid in odometer order, waits a settle interval
// per vector, then captures the controller output and streams it with its vector index.
module fuzzy_sweep_gen #(
  parameter int W          = 8,
  parameter int N_CH       = 2,
  parameter int STEP       = 16,
  parameter int RAW_MAX    = 256,
  parameter int CLAMP_LO   = 1,
  parameter int CLAMP_HI   = 254,
  parameter int SETTLE_CYC = 28,
  parameter int OUT_W      = 8,
  parameter int IDX_W      = 16
) (
  input  logic                clk_0,
  input  logic                Srst,
  input  logic                start,
  input  logic                abort,
  input  logic                continuous,
  output logic                stim_en,
  output logic [N_CH*W-1:0]   stim_out,
  input  logic [OUT_W-1:0]    dut_out,
  fuzzy_sweep_gen_if.master   res,
  output logic [7:0]          sweep_count,
  output logic                busy,
  output logic                done,
  output logic [1:0]          dbg_state_o
);

  localparam int RW  = W + 1;
  localparam int NPTS = RAW_MAX / STEP + 1;
  localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [RW-1:0]  LAST_Q      = RW'((NPTS - 1) * STEP);
  localparam logic [RW-1:0]  STEP_Q      = RW'(STEP);
  localparam logic [RW-1:0]  LO_Q        = RW'(CLAMP_LO);
  localparam logic [RW-1:0]  HI_Q        = RW'(CLAMP_HI);
  localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     raw_q [N_CH];
  logic [RW-1:0]     raw_d [N_CH];
  logic [RW-1:0]     raw_adv [N_CH];
  logic [SCW-1:0]    settle_q, settle_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;
  logic [OUT_W-1:0]  data_q, data_d;
  logic              cont_q, cont_d;
  logic [7:0]        sc_q, sc_d;
  logic              done_q, done_d;
  logic              drive_q, drive_d;
  logic              last_vec;
  logic              carry;
  logic [N_CH*W-1:0] stim;

  function automatic logic [W-1:0] clamp_fn(input logic [RW-1:0] r);
    if (r < LO_Q)      return LO_Q[W-1:0];
    else if (r > HI_Q) return HI_Q[W-1:0];
    else               return r[W-1:0];
  endfunction

  // Odometer successor: the highest channel ticks first and carries downwards.
  always_comb begin
    carry    = 1'b1;
    last_vec = 1'b1;
    for (int k = N_CH - 1; k >= 0; k--) begin
      raw_adv[k] = raw_q[k];
      if (raw_q[k] != LAST_Q) last_vec = 1'b0;
      if (carry) begin
        if (raw_q[k] == LAST_Q) begin
          raw_adv[k] = '0;
        end else begin
          raw_adv[k] = raw_q[k] + STEP_Q;
          carry      = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    raw_d    = raw_q;
    settle_d = settle_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    data_d   = data_q;
    cont_d   = cont_q;
    sc_d     = sc_q;
    done_d   = done_q;
    drive_d  = drive_q;
    if (abort) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            for (int k = 0; k < N_CH; k++) raw_d[k] = '0;
            idx_d    = '0;
            cont_d   = continuous;
            settle_d = SETTLE_LOAD;
            done_d   = 1'b0;
            drive_d  = 1'b1;
            state_d  = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_q == '0) begin
            data_d  = dut_out;
            valid_d = 1'b1;
            state_d = S_CAPTURE;
          end else begin
            settle_d = settle_q - SCW'(1);
          end
        end
        S_CAPTURE: begin
          if (valid_q && res.res_ready) begin
            valid_d = 1'b0;
            if (!last_vec) begin
              raw_d    = raw_adv;
              idx_d    = idx_q + IDX_W'(1);
              settle_d = SETTLE_LOAD;
              state_d  = S_SETTLE;
            end else if (cont_q) begin
              for (int k = 0; k < N_CH; k++) raw_d[k] = '0;
              idx_d    = '0;
              sc_d     = sc_q + 8'd1;
              settle_d = SETTLE_LOAD;
              state_d  = S_SETTLE;
            end else begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_0 or posedge Srst) begin
    if (Srst) begin
      state_q  <= S_IDLE;
      for (int k = 0; k < N_CH; k++) raw_q[k] <= '0;
      settle_q <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      cont_q   <= 1'b0;
      sc_q     <= '0;
      done_q   <= 1'b0;
      drive_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      raw_q    <= raw_d;
      settle_q <= settle_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      cont_q   <= cont_d;
      sc_q     <= sc_d;
      done_q   <= done_d;
      drive_q  <= drive_d;
    end
  end

  // Until the first start after reset the channels read 0 rather than the clamped floor.
  always_comb begin
    stim = '0;
    for (int k = 0; k < N_CH; k++) begin
      stim[k*W +: W] = drive_q ? clamp_fn(raw_q[k]) : '0;
    end
  end

  assign stim_out      = stim;
  assign busy          = (state_q == S_SETTLE) || (state_q == S_CAPTURE);
  assign stim_en       = busy;
  assign done          = done_q;
  assign sweep_count   = sc_q;
  assign dbg_state_o   = state_q;
  assign res.res_valid = valid_q;
  assign res.res_data  = data_q;
  assign res.res_index = idx_q;

endmodule

// File: tb/tb_fuzzy_sweep_gen.sv
// Bench for fuzzy_sweep_gen: a default-parameter instance for full sweeps and reset,
// and a SETTLE_CYC=4 instance for latency, backpressure, continuous mode and abort.
module tb_fuzzy_sweep_gen;
  localparam int NVEC = 289;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // instance A: defaults
  logic        a_start, a_abort, a_cont, a_stim_en, a_sc_dummy;
  logic [15:0] a_stim;
  logic [7:0]  a_dut, a_sc;
  logic        a_busy, a_done;
  logic [1:0]  a_dbg;
  fuzzy_sweep_gen_if #(.OUT_W(8), .IDX_W(16)) a_if();
  assign a_dut = a_stim[7:0] ^ a_stim[15:8];

  fuzzy_sweep_gen u_a (
    .clk_0(clk), .Srst(rst), .start(a_start), .abort(a_abort), .continuous(a_cont),
    .stim_en(a_stim_en), .stim_out(a_stim), .dut_out(a_dut), .res(a_if),
    .sweep_count(a_sc), .busy(a_busy), .done(a_done), .dbg_state_o(a_dbg)
  );

  // instance B: short settle
  logic        b_start, b_abort, b_cont, b_stim_en;
  logic [15:0] b_stim;
  logic [7:0]  b_dut, b_sc;
  logic        b_busy, b_done;
  logic [1:0]  b_dbg;
  fuzzy_sweep_gen_if #(.OUT_W(8), .IDX_W(16)) b_if();
  assign b_dut = b_stim[7:0] ^ b_stim[15:8];

  fuzzy_sweep_gen #(.SETTLE_CYC(4)) u_b (
    .clk_0(clk), .Srst(rst), .start(b_start), .abort(b_abort), .continuous(b_cont),
    .stim_en(b_stim_en), .stim_out(b_stim), .dut_out(b_dut), .res(b_if),
    .sweep_count(b_sc), .busy(b_busy), .done(b_done), .dbg_state_o(b_dbg)
  );

  // scoreboard records: {sweep_count, index, ch0, ch1, data}
  logic [47:0] exp_a_q[$];
  logic [47:0] exp_b_q[$];
  bit          a_mon_en, b_mon_en;
  int          a_got;
  logic [15:0] cap_stim [NVEC];
  logic [7:0]  cap_data [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] clampv(input int r);
    if (r < 1) return 8'd1;
    if (r > 254) return 8'd254;
    return r[7:0];
  endfunction

  function automatic logic [47:0] model(input int idx, input int sc);
    logic [7:0] c0, c1;
    c0 = clampv((idx / 17) * 16);
    c1 = clampv((idx % 17) * 16);
    return {sc[7:0], idx[15:0], c0, c1, c0 ^ c1};
  endfunction

  task automatic push_a(input int sc);
    for (int i = 0; i < NVEC; i++) exp_a_q.push_back(model(i, sc));
  endtask

  task automatic push_b(input int sc);
    for (int i = 0; i < NVEC; i++) exp_b_q.push_back(model(i, sc));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [47:0] e;
    if (!rst && a_mon_en && a_if.res_valid && a_if.res_ready) begin
      if (exp_a_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL a_unexpected_result: got index %0d expected none", a_if.res_index);
      end else begin
        e = exp_a_q.pop_front();
        check("a_result", {a_sc, a_if.res_index, a_stim[7:0], a_stim[15:8], a_if.res_data}, e);
      end
      a_got++;
      if (int'(a_if.res_index) < NVEC) begin
        cap_stim[a_if.res_index] = a_stim;
        cap_data[a_if.res_index] = a_if.res_data;
      end
    end
  end

  always @(negedge clk) begin
    logic [47:0] e;
    if (!rst && b_mon_en && b_if.res_valid && b_if.res_ready) begin
      if (exp_b_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL b_unexpected_result: got index %0d expected none", b_if.res_index);
      end else begin
        e = exp_b_q.pop_front();
        check("b_result", {b_sc, b_if.res_index, b_stim[7:0], b_stim[15:8], b_if.res_data}, e);
      end
    end
  end

  typedef struct {
    int         idx;
    logic [7:0] ch0;
    logic [7:0] ch1;
    logic [7:0] data;
  } vec_t;
  vec_t tbl [6];

  initial begin
    bit found;
    int done_seen;

    tbl[0] = '{0,   8'd1,   8'd1,   8'h00};
    tbl[1] = '{1,   8'd1,   8'd16,  8'h11};
    tbl[2] = '{16,  8'd1,   8'd254, 8'hFF};
    tbl[3] = '{17,  8'd16,  8'd1,   8'h11};
    tbl[4] = '{100, 8'd80,  8'd240, 8'hA0};
    tbl[5] = '{288, 8'd254, 8'd254, 8'h00};

    a_start = 0; a_abort = 0; a_cont = 0; a_if.res_ready = 1'b1;
    b_start = 0; b_abort = 0; b_cont = 0; b_if.res_ready = 1'b0;
    a_mon_en = 1; b_mon_en = 1; a_got = 0;
    rst = 1'b1;
    repeat (3) tick();

    check("rst_valid",   a_if.res_valid, 0);
    check("rst_busy",    a_busy, 0);
    check("rst_stim_en", a_stim_en, 0);
    check("rst_stim",    a_stim, 0);
    check("rst_index",   a_if.res_index, 0);
    check("rst_sc",      a_sc, 0);
    check("rst_done",    a_done, 0);
    check("rst_state",   a_dbg, 0);
    rst = 1'b0;
    tick();

    // full single sweep on A
    push_a(0);
    a_start = 1; tick(); a_start = 0;
    for (int c = 0; c < 12000 && !a_done; c++) tick();
    check("a_done",       a_done, 1);
    check("a_busy_end",   a_busy, 0);
    check("a_stim_en_end", a_stim_en, 0);
    check("a_count",      a_got, NVEC);
    check("a_queue_left", exp_a_q.size(), 0);
    for (int i = 0; i < 6; i++) begin
      check("tbl_stim", cap_stim[tbl[i].idx], {tbl[i].ch1, tbl[i].ch0});
      check("tbl_data", cap_data[tbl[i].idx], tbl[i].data);
    end

    // abort and start together from DONE: abort wins, done kept
    a_start = 1; a_abort = 1; tick(); a_start = 0; a_abort = 0;
    check("ab_busy",  a_busy, 0);
    check("ab_done",  a_done, 1);
    check("ab_state", a_dbg, 0);
    check("ab_stim",  a_stim, 16'hFEFE);
    tick();
    check("ab_busy2", a_busy, 0);

    // async reset mid-sweep at index 50
    push_a(0);
    a_start = 1; tick(); a_start = 0;
    found = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (a_if.res_valid && a_if.res_index == 16'd50) begin found = 1; break; end
    end
    check("a_reach_50", found, 1);
    #1 rst = 1'b1;
    #1;
    check("mrst_valid", a_if.res_valid, 0);
    check("mrst_busy",  a_busy, 0);
    check("mrst_stim",  a_stim, 0);
    check("mrst_index", a_if.res_index, 0);
    check("mrst_sc",    a_sc, 0);
    check("mrst_state", a_dbg, 0);
    exp_a_q.delete();
    tick();
    rst = 1'b0;
    tick();

    // B: settle latency of 4 edges after the start edge
    push_b(0);
    b_start = 1; tick(); b_start = 0;
    check("lat_e0_valid", b_if.res_valid, 0);
    check("lat_e0_stim",  b_stim, 16'h0101);
    check("lat_e0_busy",  b_busy, 1);
    for (int k = 1; k < 4; k++) begin
      tick();
      check("lat_valid_low", b_if.res_valid, 0);
      check("lat_stim",      b_stim, 16'h0101);
    end
    tick();
    check("lat_e4_valid", b_if.res_valid, 1);
    check("lat_e4_index", b_if.res_index, 0);
    check("lat_e4_stim",  b_stim, 16'h0101);
    check("lat_e4_data",  b_if.res_data, 0);

    // backpressure at index 5
    b_if.res_ready = 1'b1;
    found = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (b_if.res_valid && b_if.res_index == 16'd5) begin found = 1; break; end
    end
    b_if.res_ready = 1'b0;
    check("b_reach_5", found, 1);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("hold_valid", b_if.res_valid, 1);
      check("hold_index", b_if.res_index, 5);
      check("hold_data",  b_if.res_data, 8'h51);
      check("hold_stim",  b_stim, 16'h5001);
    end
    b_if.res_ready = 1'b1;
    found = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (b_if.res_valid && b_if.res_index != 16'd5) begin found = 1; break; end
    end
    check("after_hold_seen",  found, 1);
    check("after_hold_index", b_if.res_index, 6);
    for (int c = 0; c < 3000 && !b_done; c++) tick();
    check("b_done",       b_done, 1);
    check("b_queue_left", exp_b_q.size(), 0);

    // continuous: two full sweeps, a stray start while busy, then abort at index 100
    push_b(0); push_b(1); push_b(2);
    b_cont = 1; b_start = 1; tick(); b_start = 0; b_cont = 0;
    check("cont_done_cleared", b_done, 0);
    repeat (30) tick();
    b_start = 1; tick(); b_start = 0;
    done_seen = 0;
    for (int c = 0; c < 4000 && b_sc != 8'd2; c++) begin
      tick();
      if (b_done) done_seen++;
    end
    check("cont_sc",        b_sc, 2);
    check("cont_done_seen", done_seen, 0);
    found = 0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (b_if.res_valid && b_if.res_index == 16'd100) begin found = 1; break; end
    end
    check("b_reach_100", found, 1);
    b_abort = 1; b_if.res_ready = 1'b0;
    tick();
    b_abort = 0;
    check("abort_valid",   b_if.res_valid, 0);
    check("abort_stim_en", b_stim_en, 0);
    check("abort_busy",    b_busy, 0);
    check("abort_state",   b_dbg, 0);
    check("abort_stim",    b_stim, 16'hF050);
    tick();
    check("abort_stim_frozen", b_stim, 16'hF050);
    check("abort_done",        b_done, 0);
    exp_b_q.delete();

    // restart after abort begins at index 0
    b_mon_en = 0;
    b_start = 1; tick(); b_start = 0;
    check("restart_stim", b_stim, 16'h0101);
    found = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (b_if.res_valid) begin found = 1; break; end
    end
    check("restart_seen",  found, 1);
    check("restart_index", b_if.res_index, 0);
    check("restart_data",  b_if.res_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
